ga_rgb_sink: RTL and testbench

Receiving end of the Gate Array colour pins. Samples the three tri-level colour pin pairs (`*_OE_N` + value) and `HSYNC`/`VSYNC` on every `cen_16` tick, decodes each channel to a level (0, half, full), and emits 8-bit RGB plus the firmware colour number. It tracks beam position from the sync edges and produces windowed pixel coordinates, line/frame strobes and sync-loss flags. It sits between the GA40010 core and the scaler/framebuffer writer.

---
 rtl/ga_rgb_sink.sv | 240 ++++++++++++++++++++++++
 tb/tb_ga_rgb_sink.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_rgb_sink.sv
// ga_rgb_sink
// Receiving end of the Gate Array colour pins. Samples the tri-level colour
// pin pairs and the sync pins on every 16 MHz tick, decodes each channel to
// 8-bit RGB plus the firmware colour number, and tracks beam position from
// the sync falling edges to produce windowed pixel coordinates, line/frame
// strobes, the last line length and sticky sync-loss flags.
//
// Ports
//   clk, RESET_N (async, active-low), cen_16 (tick enable)
//   RED_OE_N/RED, GREEN_OE_N/GREEN, BLUE_OE_N/BLUE : colour pins (OE_N=1 -> half)
//   HSYNC, VSYNC                                    : sync pins, active-high
//   R, G, B, FW_COLOUR                              : decoded colour
//   PIX_VALID, PIX_X, PIX_Y                         : active-window position
//   LINE_START, FRAME_START                         : one-tick strobes
//   LINE_LEN                                        : ticks in last completed line
//   HSYNC_LOST, VSYNC_LOST                          : sticky sync-loss flags
//
// Pins sampled on tick n are visible on every output after tick n+1; all
// outputs come from one register stage and are mutually aligned.
module ga_rgb_sink #(
  parameter logic [9:0] H_START    = 10'd160,
  parameter logic [9:0] H_WIDTH    = 10'd768,
  parameter logic [8:0] V_START    = 9'd32,
  parameter logic [8:0] V_HEIGHT   = 9'd272,
  parameter logic [7:0] HALF_LEVEL = 8'h80
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       cen_16,
  input  logic       RED_OE_N,
  input  logic       RED,
  input  logic       GREEN_OE_N,
  input  logic       GREEN,
  input  logic       BLUE_OE_N,
  input  logic       BLUE,
  input  logic       HSYNC,
  input  logic       VSYNC,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic [4:0] FW_COLOUR,
  output logic       PIX_VALID,
  output logic [9:0] PIX_X,
  output logic [8:0] PIX_Y,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic [9:0] LINE_LEN,
  output logic       HSYNC_LOST,
  output logic       VSYNC_LOST
);

  // Bit positions of the pins inside the stage-1 sample vector.
  localparam int P_ROE = 0;
  localparam int P_RED = 1;
  localparam int P_GOE = 2;
  localparam int P_GRN = 3;
  localparam int P_BOE = 4;
  localparam int P_BLU = 5;
  localparam int P_HS  = 6;
  localparam int P_VS  = 7;

  // Window bounds widened by one bit so START+WIDTH cannot wrap.
  localparam logic [10:0] H_LO = {1'b0, H_START};
  localparam logic [10:0] H_HI = {1'b0, H_START} + {1'b0, H_WIDTH};
  localparam logic [9:0]  V_LO = {1'b0, V_START};
  localparam logic [9:0]  V_HI = {1'b0, V_START} + {1'b0, V_HEIGHT};

  // OE_N released -> half level; driven -> off or full by pin value.
  function automatic logic [1:0] lvl(input logic oe_n, input logic v);
    if (oe_n) return 2'd1;
    return v ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [7:0] lvl_to_8(input logic [1:0] l);
    case (l)
      2'd1:    return HALF_LEVEL;
      2'd2:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] s1_q, s1_d;
  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       vs_pend_q, vs_pend_d;
  logic       hs_lost_q, hs_lost_d, vs_lost_q, vs_lost_d;
  logic [9:0] line_len_q, line_len_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [4:0] fw_q, fw_d;
  logic       pix_valid_q, pix_valid_d;
  logic [9:0] pix_x_q, pix_x_d;
  logic [8:0] pix_y_q, pix_y_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic       hs_lost_o_q, hs_lost_o_d, vs_lost_o_q, vs_lost_o_d;

  logic       hs_fall, vs_fall, in_win;
  logic [1:0] r_lvl, g_lvl, b_lvl;

  always_comb begin
    s1_d          = s1_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    x_d           = x_q;
    y_d           = y_q;
    vs_pend_d     = vs_pend_q;
    hs_lost_d     = hs_lost_q;
    vs_lost_d     = vs_lost_q;
    line_len_d    = line_len_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    fw_d          = fw_q;
    pix_valid_d   = pix_valid_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    hs_lost_o_d   = hs_lost_o_q;
    vs_lost_o_d   = vs_lost_o_q;
    hs_fall       = 1'b0;
    vs_fall       = 1'b0;
    in_win        = 1'b0;
    r_lvl         = lvl(s1_q[P_ROE], s1_q[P_RED]);
    g_lvl         = lvl(s1_q[P_GOE], s1_q[P_GRN]);
    b_lvl         = lvl(s1_q[P_BOE], s1_q[P_BLU]);

    if (cen_16) begin
      s1_d      = {VSYNC, HSYNC, BLUE, BLUE_OE_N, GREEN, GREEN_OE_N, RED, RED_OE_N};
      hs_prev_d = s1_q[P_HS];
      vs_prev_d = s1_q[P_VS];
      hs_fall   = hs_prev_q & ~s1_q[P_HS];
      vs_fall   = vs_prev_q & ~s1_q[P_VS];

      line_start_d  = hs_fall;
      frame_start_d = 1'b0;

      if (hs_fall) begin
        // A line that ran into saturation has no meaningful length. A
        // 1024-tick line wraps to 0 in this 10-bit field.
        if (!hs_lost_q) line_len_d = x_q + 10'd1;
        hs_lost_d = 1'b0;
        x_d       = '0;
        if (vs_pend_q | vs_fall) begin
          y_d           = '0;
          vs_pend_d     = 1'b0;
          vs_lost_d     = 1'b0;
          frame_start_d = 1'b1;
        end else if (y_q == 9'h1FF) begin
          vs_lost_d = 1'b1;
        end else begin
          y_d = y_q + 9'd1;
        end
      end else begin
        // Flag only when an increment is blocked, so a full 1024-tick
        // line (x reaching 1023 then falling) is not a loss.
        if (x_q == 10'h3FF) hs_lost_d = 1'b1;
        else                x_d = x_q + 10'd1;
        if (vs_fall) vs_pend_d = 1'b1;
      end

      in_win = ({1'b0, x_d} >= H_LO) && ({1'b0, x_d} < H_HI) &&
               ({1'b0, y_d} >= V_LO) && ({1'b0, y_d} < V_HI);

      pix_valid_d = in_win;
      pix_x_d     = in_win ? (x_d - H_START) : '0;
      pix_y_d     = in_win ? (y_d - V_START) : '0;

      r_d  = lvl_to_8(r_lvl);
      g_d  = lvl_to_8(g_lvl);
      b_d  = lvl_to_8(b_lvl);
      fw_d = {3'b0, g_lvl} * 5'd9 + {3'b0, r_lvl} * 5'd3 + {3'b0, b_lvl};

      hs_lost_o_d = hs_lost_d;
      vs_lost_o_d = vs_lost_d;
    end
  end

  // Flag state resets set (no sync seen yet); the flag outputs reset to 0
  // like every other output and pick the state up on the first tick.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q          <= '0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      x_q           <= 10'h3FF;
      y_q           <= 9'h1FF;
      vs_pend_q     <= 1'b0;
      hs_lost_q     <= 1'b1;
      vs_lost_q     <= 1'b1;
      line_len_q    <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      fw_q          <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_lost_o_q   <= 1'b0;
      vs_lost_o_q   <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      x_q           <= x_d;
      y_q           <= y_d;
      vs_pend_q     <= vs_pend_d;
      hs_lost_q     <= hs_lost_d;
      vs_lost_q     <= vs_lost_d;
      line_len_q    <= line_len_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      fw_q          <= fw_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_lost_o_q   <= hs_lost_o_d;
      vs_lost_o_q   <= vs_lost_o_d;
    end
  end

  assign R           = r_q;
  assign G           = g_q;
  assign B           = b_q;
  assign FW_COLOUR   = fw_q;
  assign PIX_VALID   = pix_valid_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;
  assign LINE_LEN    = line_len_q;
  assign HSYNC_LOST  = hs_lost_o_q;
  assign VSYNC_LOST  = vs_lost_o_q;

endmodule

// File: tb/tb_ga_rgb_sink.sv
// Bench for ga_rgb_sink: directed sequence with randomized colour pins,
// checked every tick against a beam-position reference model.
module tb_ga_rgb_sink;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET_N, cen_16;
  logic       RED_OE_N, RED, GREEN_OE_N, GREEN, BLUE_OE_N, BLUE, HSYNC, VSYNC;
  logic [7:0] R, G, B;
  logic [4:0] FW_COLOUR;
  logic       PIX_VALID;
  logic [9:0] PIX_X;
  logic [8:0] PIX_Y;
  logic       LINE_START, FRAME_START;
  logic [9:0] LINE_LEN;
  logic       HSYNC_LOST, VSYNC_LOST;

  ga_rgb_sink dut (
    .clk(clk), .RESET_N(RESET_N), .cen_16(cen_16),
    .RED_OE_N(RED_OE_N), .RED(RED), .GREEN_OE_N(GREEN_OE_N), .GREEN(GREEN),
    .BLUE_OE_N(BLUE_OE_N), .BLUE(BLUE), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .R(R), .G(G), .B(B), .FW_COLOUR(FW_COLOUR),
    .PIX_VALID(PIX_VALID), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START), .LINE_LEN(LINE_LEN),
    .HSYNC_LOST(HSYNC_LOST), .VSYNC_LOST(VSYNC_LOST)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] r, g, b;
    logic [4:0] fw;
    logic       valid;
    logic [9:0] px;
    logic [8:0] py;
    logic       ls, fs;
    logic [9:0] len;
    logic       hl, vl;
  } exp_t;

  exp_t       e;
  logic [7:0] lut [3] = '{8'h00, 8'h80, 8'hFF};
  logic [7:0] m_s1, m_prev;   // pins of the last tick and the one before
  int         mx, my, mlen;
  bit         mpend, mhl, mvl;

  int ls_cnt = 0, fs_cnt = 0, valid_cnt = 0;

  function automatic int lvl_of(input logic oe_n, input logic v);
    if (oe_n) return 1;
    return v ? 2 : 0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_prev = '0;
    mx = 1023; my = 511; mlen = 0;
    mpend = 0; mhl = 1; mvl = 1;
    e.r = '0; e.g = '0; e.b = '0; e.fw = '0; e.valid = 1'b0;
    e.px = '0; e.py = '0; e.ls = 1'b0; e.fs = 1'b0;
    e.len = '0; e.hl = 1'b0; e.vl = 1'b0;
  endtask

  // Advance the beam by one tick; p is the pin set sampled on this tick.
  task automatic model_step(input logic [7:0] p);
    bit hfall, vfall;
    int lr, lg, lb;
    hfall = m_prev[6] && !m_s1[6];
    vfall = m_prev[7] && !m_s1[7];
    e.ls = 1'b0; e.fs = 1'b0;
    if (hfall) begin
      if (!mhl) mlen = (mx + 1) % 1024;
      mhl = 0; mx = 0; e.ls = 1'b1;
      if (mpend || vfall) begin
        my = 0; mpend = 0; mvl = 0; e.fs = 1'b1;
      end else if (my == 511) mvl = 1;
      else my = my + 1;
    end else begin
      if (mx == 1023) mhl = 1;
      else mx = mx + 1;
      if (vfall) mpend = 1;
    end
    lr = lvl_of(m_s1[0], m_s1[1]);
    lg = lvl_of(m_s1[2], m_s1[3]);
    lb = lvl_of(m_s1[4], m_s1[5]);
    e.r = lut[lr]; e.g = lut[lg]; e.b = lut[lb];
    e.fw = 5'(9 * lg + 3 * lr + lb);
    e.valid = (mx >= 160) && (mx < 160 + 768) && (my >= 32) && (my < 32 + 272);
    e.px = e.valid ? 10'(mx - 160) : 10'd0;
    e.py = e.valid ? 9'(my - 32) : 9'd0;
    e.len = 10'(mlen);
    e.hl = mhl; e.vl = mvl;
    m_prev = m_s1;
    m_s1 = p;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("r", R, e.r);
    chk("g", G, e.g);
    chk("b", B, e.b);
    chk("fw_colour", FW_COLOUR, e.fw);
    chk("pix_valid", PIX_VALID, e.valid);
    chk("pix_x", PIX_X, e.px);
    chk("pix_y", PIX_Y, e.py);
    chk("line_start", LINE_START, e.ls);
    chk("frame_start", FRAME_START, e.fs);
    chk("line_len", LINE_LEN, e.len);
    chk("hsync_lost", HSYNC_LOST, e.hl);
    chk("vsync_lost", VSYNC_LOST, e.vl);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [7:0] p);
    {VSYNC, HSYNC, BLUE, BLUE_OE_N, GREEN, GREEN_OE_N, RED, RED_OE_N} = p;
  endtask

  task automatic tick(input logic [7:0] p);
    drive(p);
    cen_16 = 1'b1;
    @(posedge clk);
    #1;
    model_step(p);
    check_all();
    if (LINE_START === 1'b1) ls_cnt++;
    if (FRAME_START === 1'b1) fs_cnt++;
    if (PIX_VALID === 1'b1) valid_cnt++;
  endtask

  // Clock edges with cen_16 low and the pins wiggling: nothing may move.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cen_16 = 1'b0;
      drive(8'($urandom));
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  function automatic logic [7:0] mk(input logic hs, input logic vs);
    return {vs, hs, 6'($urandom_range(0, 63))};
  endfunction

  // HSYNC high for the first hs_hi ticks, VSYNC high for the first vs_hi.
  task automatic run_line(input int len, input int hs_hi, input int vs_hi);
    for (int i = 0; i < len; i++) tick(mk(i < hs_hi, i < vs_hi));
  endtask

  function automatic logic [1:0] pin_pair(input int lv);
    if (lv == 1) return {1'($urandom_range(0, 1)), 1'b1};
    return (lv == 2) ? 2'b10 : 2'b00;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int snap, vs_hi, len;

    RESET_N = 1'b0;
    cen_16  = 1'b0;
    drive(8'h00);
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    RESET_N = 1'b1;

    // Latency and the worked example: R half, G full, B off.
    tick(8'b0000_1001);
    chk("lat_r_tick1", R, 8'h00);
    tick(8'b0000_0000);
    chk("ex_r", R, 8'h80);
    chk("ex_g", G, 8'hFF);
    chk("ex_b", B, 8'h00);
    chk("ex_fw", FW_COLOUR, 5'd21);

    // All 27 level combinations (sync pins low).
    for (int lg = 0; lg < 3; lg++)
      for (int lr = 0; lr < 3; lr++)
        for (int lb = 0; lb < 3; lb++)
          tick({2'b00, pin_pair(lb), pin_pair(lg), pin_pair(lr)});
    tick(8'h00);
    tick(8'h00);

    // Frame: 312 lines, VSYNC falling mid-line; four 1024-tick lines.
    snap = ls_cnt;
    fs_cnt = 0;
    for (int ln = 0; ln < 320; ln++) begin
      len = (ln >= 35 && ln <= 38) ? 1024 : 170;
      if (ln == 1 || ln == 2 || ln == 313 || ln == 314) vs_hi = len;
      else if (ln == 3 || ln == 315) vs_hi = 90;
      else vs_hi = 0;
      valid_cnt = 0;
      run_line(len, 16, vs_hi);
      if (ln == 35) chk("valid_cnt_y31", valid_cnt, 0);
      if (ln == 36) chk("valid_cnt_y32", valid_cnt, 768);
      if (ln == 37) chk("line_len_1024", LINE_LEN, 10'd0);
      if (ln == 40) chk("line_len_170", LINE_LEN, 10'd170);
    end
    chk("line_start_count", ls_cnt - snap, 320);
    chk("frame_start_count", fs_cnt, 2);

    // HSYNC stuck low: saturation, then one fall leaves LINE_LEN alone.
    for (int i = 0; i < 2000; i++) tick(mk(1'b0, 1'b0));
    chk("loss_flag_set", HSYNC_LOST, 1'b1);
    chk("loss_len_before", LINE_LEN, 10'd170);
    for (int i = 0; i < 5; i++) tick(mk(1'b1, 1'b0));
    for (int i = 0; i < 3; i++) tick(mk(1'b0, 1'b0));
    chk("loss_len_after", LINE_LEN, 10'd170);
    chk("loss_flag_clear", HSYNC_LOST, 1'b0);

    // VSYNC and HSYNC falling on the same tick.
    run_line(170, 16, 170);
    snap = fs_cnt;
    run_line(170, 16, 16);
    chk("same_tick_frame", fs_cnt - snap, 1);

    // Random pins with gated ticks.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      else tick(8'($urandom));
    end

    // Walk into the active window, then reset with cen_16 gated.
    run_line(170, 16, 170);
    run_line(170, 16, 90);
    for (int ln = 0; ln < 32; ln++) run_line(170, 16, 0);
    run_line(500, 16, 0);
    chk("in_window_before_reset", PIX_VALID, 1'b1);
    cen_16 = 1'b0;
    drive(mk(1'b0, 1'b0));
    RESET_N = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all();
    end
    RESET_N = 1'b1;
    snap = ls_cnt;
    for (int i = 0; i < 20; i++) tick(mk(1'b0, 1'b0));
    chk("no_strobe_after_reset", ls_cnt - snap, 0);
    run_line(200, 16, 0);
    chk("first_strobe_after_reset", ls_cnt - snap, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
